// File: rtl/gpio_seq_pkg.sv
// Shared constants for the GPIO pattern sequencer: CSR map, CTRL bit layout and FSM encoding.
package gpio_seq_pkg;

  localparam logic [1:0] CsrCtrl    = 2'd0;
  localparam logic [1:0] CsrDwell   = 2'd1;
  localparam logic [1:0] CsrPatIdx  = 2'd2;
  localparam logic [1:0] CsrPatData = 2'd3;

  localparam int unsigned CtrlRun    = 0;
  localparam int unsigned CtrlLoop   = 1;
  localparam int unsigned CtrlDone   = 2;
  localparam int unsigned CtrlLenLsb = 8;
  localparam int unsigned CtrlLenMsb = 15;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StDwell = 2'd2
  } seq_state_e;

endpackage

// File: rtl/gpio_pattern_sequencer_if.sv
// Avalon-MM style register bus used for both the CSR slave port and the PIO master port.
interface gpio_pattern_sequencer_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/gpio_seq_pattern_ram.sv
// Pattern table: one synchronous write port, two asynchronous read ports (CSR and sequencer).
module gpio_seq_pattern_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned IdxW  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [IdxW-1:0]   waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IdxW-1:0]   raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [IdxW-1:0]   raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/gpio_pattern_sequencer.sv
// Replays a table of output patterns onto the PIO register, one per dwell period, once or looped.
module gpio_pattern_sequencer
  import gpio_seq_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned DWELL_W = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  gpio_pattern_sequencer_if.slave  csr,
  gpio_pattern_sequencer_if.master pio,
  output logic                     busy
);

  localparam int unsigned IdxW     = $clog2(DEPTH);
  localparam logic [8:0]  DepthLen = 9'(DEPTH);

  seq_state_e         state_q, state_d;
  logic [7:0]         step_q, step_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [DWELL_W-1:0] dwell_q;
  logic [7:0]         len_q;
  logic               loop_q;
  logic [IdxW-1:0]    idx_q;
  logic               m_cs_q;
  logic [DATA_W-1:0]  m_wd_q;

  logic              csr_we, ctrl_we, pat_we, start, stop, advance, last_step;
  logic [8:0]        eff_len;
  logic [DATA_W-1:0] csr_rdata, seq_rdata;
  logic              unused_bits;

  assign csr_we  = csr.chipselect & ~csr.write_n;
  assign ctrl_we = csr_we & (csr.address == CsrCtrl);
  assign pat_we  = csr_we & (csr.address == CsrPatData);
  assign start   = ctrl_we & csr.writedata[CtrlRun] & (state_q == StIdle) &
                   (csr.writedata[CtrlLenMsb:CtrlLenLsb] != 8'd0);
  assign stop    = ctrl_we & ~csr.writedata[CtrlRun] & (state_q != StIdle);

  // len_q only changes while idle, so the clamped length is stable for a whole run.
  assign eff_len   = ({1'b0, len_q} > DepthLen) ? DepthLen : {1'b0, len_q};
  assign last_step = ({1'b0, step_q} == (eff_len - 9'd1));

  gpio_seq_pattern_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i    (clk),
    .rst_i    (reset),
    .we_i     (pat_we),
    .waddr_i  (idx_q),
    .wdata_i  (csr.writedata[DATA_W-1:0]),
    .raddr_a_i(idx_q),
    .rdata_a_o(csr_rdata),
    .raddr_b_i(step_q[IdxW-1:0]),
    .rdata_b_o(seq_rdata)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    advance = 1'b0;
    if (ctrl_we && csr.writedata[CtrlDone]) done_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWrite;
          step_d  = 8'd0;
          done_d  = 1'b0;
        end
      end
      StWrite: begin
        if (dwell_q == '0) begin
          advance = 1'b1;
        end else begin
          cnt_d   = dwell_q;
          state_d = StDwell;
        end
      end
      StDwell: begin
        if (cnt_q == DWELL_W'(1)) advance = 1'b1;
        else                      cnt_d   = cnt_q - DWELL_W'(1);
      end
      default: state_d = StIdle;
    endcase
    if (advance) begin
      if (!last_step) begin
        step_d  = step_q + 8'd1;
        state_d = StWrite;
      end else if (loop_q) begin
        step_d  = 8'd0;
        state_d = StWrite;
      end else begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
    end
    // An abort never reports completion.
    if (stop) begin
      state_d = StIdle;
      done_d  = done_q & ~csr.writedata[CtrlDone];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      step_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dwell_q <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      idx_q   <= '0;
      m_cs_q  <= 1'b0;
      m_wd_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      m_cs_q  <= (state_q == StWrite);
      if (state_q == StWrite) m_wd_q <= seq_rdata;
      if (ctrl_we) begin
        loop_q <= csr.writedata[CtrlLoop];
        if (state_q == StIdle) len_q <= csr.writedata[CtrlLenMsb:CtrlLenLsb];
      end
      if (csr_we && (csr.address == CsrDwell)) dwell_q <= csr.writedata[DWELL_W-1:0];
      if (csr_we && (csr.address == CsrPatIdx)) idx_q <= csr.writedata[IdxW-1:0];
      else if (pat_we)                          idx_q <= idx_q + IdxW'(1);
    end
  end

  assign busy = (state_q != StIdle);

  always_comb begin
    csr.readdata = '0;
    case (csr.address)
      CsrCtrl:    csr.readdata = {8'd0, step_q, len_q, 5'd0, done_q, loop_q, busy};
      CsrDwell:   csr.readdata = 32'(dwell_q);
      CsrPatIdx:  csr.readdata = 32'(idx_q);
      CsrPatData: csr.readdata = 32'(csr_rdata);
      default:    csr.readdata = '0;
    endcase
  end

  assign pio.address    = 2'd0;
  assign pio.chipselect = m_cs_q;
  assign pio.write_n    = ~m_cs_q;
  assign pio.writedata  = 32'(m_wd_q);

  assign unused_bits = ^{csr.writedata, pio.readdata};

endmodule

// File: tb/tb_gpio_pattern_sequencer.sv
// Directed bench for gpio_pattern_sequencer: CSR programming, strobe timing, loop/stop, reset.
module tb_gpio_pattern_sequencer;
  import gpio_seq_pkg::*;

  typedef struct {
    int unsigned cyc;
    logic [31:0] data;
  } strobe_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;
  int unsigned cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;
  strobe_t strobes[$];

  gpio_pattern_sequencer_if csr_if ();
  gpio_pattern_sequencer_if pio_if ();

  gpio_pattern_sequencer #(
    .DATA_W (16),
    .DEPTH  (8),
    .DWELL_W(24)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .csr  (csr_if),
    .pio  (pio_if),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pio_if.chipselect === 1'b1 && pio_if.write_n === 1'b0)
      strobes.push_back('{cyc: cyc, data: pio_if.writedata});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    csr_if.address    = a;
    csr_if.writedata  = d;
    csr_if.chipselect = 1'b1;
    csr_if.write_n    = 1'b0;
    @(posedge clk);
    #1;
    csr_if.chipselect = 1'b0;
    csr_if.write_n    = 1'b1;
  endtask

  task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
    csr_if.address    = a;
    csr_if.chipselect = 1'b1;
    csr_if.write_n    = 1'b1;
    #1;
    d = csr_if.readdata;
    @(posedge clk);
    #1;
    csr_if.chipselect = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tests_run++;
    if (pio_if.chipselect !== 1'b0 || pio_if.write_n !== 1'b1 || pio_if.writedata !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_master: cs=%b wn=%b wd=%h, want cs=0 wn=1 wd=0",
               pio_if.chipselect, pio_if.write_n, pio_if.writedata);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    for (int a = 0; a < 4; a++) begin
      csr_read(2'(a), rd);
      tests_run++;
      if (rd !== 32'd0) begin
        tests_failed++;
        $display("FAIL reset_csr%0d: got %h want 0", a, rd);
      end
    end
  endtask

  task automatic test_single_shot;
    logic [31:0] rd;
    logic [31:0] exp_d[3];
    int unsigned t0;
    exp_d = '{32'h1, 32'h2, 32'h4};
    csr_write(CsrPatIdx, 32'd0);
    for (int i = 0; i < 3; i++) csr_write(CsrPatData, exp_d[i]);
    csr_write(CsrDwell, 32'd4);
    strobes.delete();
    csr_write(CsrCtrl, 32'h0000_0301);
    t0 = cyc;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_busy_start: got %b want 1", busy);
    end
    tick(25);
    tests_run++;
    if (strobes.size() != 3) begin
      tests_failed++;
      $display("FAIL single_count: got %0d strobes want 3", strobes.size());
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (i >= strobes.size() || strobes[i].data !== exp_d[i] ||
          strobes[i].cyc != t0 + 1 + 5 * i) begin
        tests_failed++;
        $display("FAIL single_strobe%0d: got data %h cyc %0d want data %h cyc %0d", i,
                 (i < strobes.size()) ? strobes[i].data : 32'hx,
                 (i < strobes.size()) ? strobes[i].cyc : 0, exp_d[i], t0 + 1 + 5 * i);
      end
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_busy_end: got %b want 0", busy);
    end
    csr_read(CsrCtrl, rd);
    tests_run++;
    if (rd !== 32'h0002_0304) begin
      tests_failed++;
      $display("FAIL single_ctrl: got %h want 00020304", rd);
    end
  endtask

  task automatic test_loop_stop;
    logic [31:0] rd;
    int unsigned t0, tw;
    int late;
    csr_write(CsrCtrl, 32'h0000_0004);
    csr_write(CsrDwell, 32'd0);
    strobes.delete();
    csr_write(CsrCtrl, 32'h0000_0203);
    t0 = cyc;
    tick(10);
    tests_run++;
    if (strobes.size() < 8) begin
      tests_failed++;
      $display("FAIL loop_count: got %0d strobes want >= 8", strobes.size());
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (i >= strobes.size() || strobes[i].data !== ((i % 2 == 0) ? 32'h1 : 32'h2) ||
          strobes[i].cyc != t0 + 1 + i) begin
        tests_failed++;
        $display("FAIL loop_strobe%0d: got data %h cyc %0d want data %h cyc %0d", i,
                 (i < strobes.size()) ? strobes[i].data : 32'hx,
                 (i < strobes.size()) ? strobes[i].cyc : 0,
                 (i % 2 == 0) ? 32'h1 : 32'h2, t0 + 1 + i);
      end
    end
    csr_write(CsrCtrl, 32'h0000_0202);
    tw = cyc;
    tick(5);
    late = 0;
    foreach (strobes[i]) if (strobes[i].cyc >= tw + 1) late++;
    tests_run++;
    if (late != 0) begin
      tests_failed++;
      $display("FAIL stop_late_strobes: got %0d want 0", late);
    end
    csr_read(CsrCtrl, rd);
    tests_run++;
    if (busy !== 1'b0 || rd[2:0] !== 3'b010) begin
      tests_failed++;
      $display("FAIL stop_state: busy=%b ctrl[2:0]=%b want busy=0 ctrl[2:0]=010", busy, rd[2:0]);
    end
  endtask

  task automatic test_len_bounds;
    logic [31:0] rd;
    int unsigned t0;
    strobes.delete();
    csr_write(CsrCtrl, 32'h0000_0001);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL len0_busy: got %b want 0", busy);
    end
    tick(5);
    tests_run++;
    if (strobes.size() != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL len0_idle: strobes=%0d busy=%b want 0 0", strobes.size(), busy);
    end
    csr_write(CsrPatIdx, 32'd0);
    for (int i = 0; i < 8; i++) csr_write(CsrPatData, 32'h10 + i);
    strobes.delete();
    csr_write(CsrCtrl, 32'h0000_1401);
    t0 = cyc;
    tick(15);
    tests_run++;
    if (strobes.size() != 8) begin
      tests_failed++;
      $display("FAIL len20_count: got %0d strobes want 8", strobes.size());
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (i >= strobes.size() || strobes[i].data !== 32'h10 + i ||
          strobes[i].cyc != t0 + 1 + i) begin
        tests_failed++;
        $display("FAIL len20_strobe%0d: got data %h cyc %0d want data %h cyc %0d", i,
                 (i < strobes.size()) ? strobes[i].data : 32'hx,
                 (i < strobes.size()) ? strobes[i].cyc : 0, 32'h10 + i, t0 + 1 + i);
      end
    end
    csr_read(CsrCtrl, rd);
    tests_run++;
    if (busy !== 1'b0 || (rd & 32'h00FF_0007) !== 32'h0007_0004) begin
      tests_failed++;
      $display("FAIL len20_end: busy=%b ctrl=%h want busy=0 step=7 done=1", busy, rd);
    end
  endtask

  task automatic test_table_access;
    logic [31:0] rd;
    logic found;
    int n_new, n_old, n_other;
    csr_write(CsrPatIdx, 32'd7);
    csr_write(CsrPatData, 32'hAAAA);
    csr_write(CsrPatData, 32'hBBBB);
    csr_read(CsrPatIdx, rd);
    tests_run++;
    if (rd !== 32'd1) begin
      tests_failed++;
      $display("FAIL idx_wrap: got %h want 1", rd);
    end
    csr_write(CsrPatIdx, 32'd7);
    csr_read(CsrPatData, rd);
    tests_run++;
    if (rd !== 32'hAAAA) begin
      tests_failed++;
      $display("FAIL entry7: got %h want aaaa", rd);
    end
    csr_read(CsrPatIdx, rd);
    tests_run++;
    if (rd !== 32'd7) begin
      tests_failed++;
      $display("FAIL read_no_incr: got %h want 7", rd);
    end
    csr_write(CsrPatIdx, 32'd0);
    csr_read(CsrPatData, rd);
    tests_run++;
    if (rd !== 32'hBBBB) begin
      tests_failed++;
      $display("FAIL entry0: got %h want bbbb", rd);
    end
    csr_write(CsrDwell, 32'd3);
    strobes.delete();
    csr_write(CsrCtrl, 32'h0000_0203);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1);
      if (strobes.size() > 0 && strobes[strobes.size() - 1].data === 32'h11) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL live_first_step1: got no strobe with 0011 want one within 40 cycles");
    end
    csr_write(CsrPatIdx, 32'd1);
    csr_write(CsrPatData, 32'h5555);
    strobes.delete();
    tick(20);
    csr_write(CsrCtrl, 32'h0000_0202);
    tick(3);
    n_new = 0;
    n_old = 0;
    n_other = 0;
    foreach (strobes[i]) begin
      if (strobes[i].data === 32'h5555)      n_new++;
      else if (strobes[i].data === 32'h11)   n_old++;
      else if (strobes[i].data !== 32'hBBBB) n_other++;
    end
    tests_run++;
    if (n_new < 2 || n_old != 0 || n_other != 0) begin
      tests_failed++;
      $display("FAIL live_update: got new=%0d old=%0d other=%0d want new>=2 old=0 other=0",
               n_new, n_old, n_other);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    logic found;
    csr_write(CsrDwell, 32'd10);
    strobes.delete();
    csr_write(CsrCtrl, 32'h0000_0203);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (strobes.size() > 0) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL rstmid_start: got no strobe want one within 20 cycles");
    end
    tick(3);
    reset = 1'b1;
    strobes.delete();
    tick(1);
    reset = 1'b0;
    tick(20);
    tests_run++;
    if (strobes.size() != 0) begin
      tests_failed++;
      $display("FAIL rstmid_strobes: got %0d want 0", strobes.size());
    end
    tests_run++;
    if (pio_if.chipselect !== 1'b0 || pio_if.write_n !== 1'b1 || pio_if.writedata !== 32'd0 ||
        busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: cs=%b wn=%b wd=%h busy=%b want 0 1 0 0",
               pio_if.chipselect, pio_if.write_n, pio_if.writedata, busy);
    end
    for (int a = 0; a < 4; a++) begin
      csr_read(2'(a), rd);
      tests_run++;
      if (rd !== 32'd0) begin
        tests_failed++;
        $display("FAIL rstmid_csr%0d: got %h want 0", a, rd);
      end
    end
  endtask

  initial begin
    csr_if.address    = 2'd0;
    csr_if.chipselect = 1'b0;
    csr_if.write_n    = 1'b1;
    csr_if.writedata  = 32'd0;
    pio_if.readdata   = 32'd0;
    #1;
    test_reset();
    test_single_shot();
    test_loop_stop();
    test_len_bounds();
    test_table_access();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
